// File: rtl/eth_mgmt_pkg.sv
// Shared definitions for the Ethernet PHY management (SMI/MDIO) controller.
// Holds the controller state encoding, Clause 22 frame field codes and the
// frame layout lengths used to locate field boundaries within a 64-bit frame.
package eth_mgmt_pkg;

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } mgmt_state_e;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] TA_WR = 2'b10;

  localparam int unsigned PRE_LEN   = 32;
  localparam int unsigned HDR_LEN   = 14;
  localparam int unsigned TA_LEN    = 2;
  localparam int unsigned FRAME_LEN = 64;

endpackage

// File: rtl/mdc_tick_gen.sv
// MDC generator for the management controller.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : frame active; when low the divider idles at phase 0, MDC low
//   restart    : forces phase 0 (asserted on request acceptance)
//   rise_tick  : strobe in the last low cycle; MDC is high from the next cycle
//   fall_tick  : strobe in the last high cycle; next bit starts the next cycle
//   eth_mdc    : management clock, CLK_DIV cycles per half-period
module mdc_tick_gen #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic rise_tick,
  output logic fall_tick,
  output logic eth_mdc
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          wrap;

  always_comb begin
    wrap      = en && (cnt_q == LAST);
    rise_tick = wrap && !mdc_q;
    fall_tick = wrap && mdc_q;
    cnt_d     = cnt_q;
    mdc_d     = mdc_q;
    if (restart || !en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      mdc_d = !mdc_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign eth_mdc = mdc_q;

endmodule

// File: rtl/eth_phy_mgmt_ctrl.sv
// Ethernet PHY management controller: holds the PHY in hardware reset for
// RST_HOLD cycles after reset, then serialises single register read/write
// requests as Clause 22 MDIO frames.
// Ports:
//   sys_clk, rst                  : clock, asynchronous active-high reset
//   req_valid/req_ready           : request handshake (ready only when idle)
//   req_rd, req_phy, req_reg,
//   req_wdata                     : request fields, captured on acceptance
//   done                          : one-cycle pulse at frame completion
//   rd_data, rd_err               : read result / missing-TA-zero flag
//   phy_rst_n                     : PHY hardware reset, active low
//   eth_mdc, mdio_o, mdio_oe,
//   mdio_i                        : SMI pins (tristate split)
module eth_phy_mgmt_ctrl
  import eth_mgmt_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 10,
  parameter int unsigned RST_HOLD = 20
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        phy_rst_n,
  output logic        eth_mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int unsigned   HW        = $clog2(RST_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [5:0]    BIT_HDR   = 6'(PRE_LEN);
  localparam logic [5:0]    BIT_TA    = 6'(PRE_LEN + HDR_LEN);
  localparam logic [5:0]    BIT_DATA  = 6'(PRE_LEN + HDR_LEN + TA_LEN);
  localparam logic [5:0]    BIT_TA2   = BIT_DATA - 6'd1;
  localparam logic [5:0]    BIT_LAST  = 6'(FRAME_LEN - 1);

  mgmt_state_e   state_q, state_d;
  logic [5:0]    bit_q, bit_d, nb;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   tx_q, tx_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rx_q, rx_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_q, rd_d;
  logic          ta_err_q, ta_err_d;
  logic          rd_err_q, rd_err_d;
  logic          phy_rst_n_q, phy_rst_n_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          accept, frame_en, rise_tick, fall_tick;

  assign frame_en = (state_q == S_PRE) || (state_q == S_HDR) ||
                    (state_q == S_TA)  || (state_q == S_DATA);

  mdc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (sys_clk),
    .rst      (rst),
    .en       (frame_en),
    .restart  (accept),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .eth_mdc  (eth_mdc)
  );

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    hold_d      = hold_q;
    tx_d        = tx_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    rd_data_d   = rd_data_q;
    rd_d        = rd_q;
    ta_err_d    = ta_err_q;
    rd_err_d    = rd_err_q;
    phy_rst_n_d = phy_rst_n_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    accept      = 1'b0;
    nb          = bit_q + 6'd1;

    case (state_q)
      S_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d     = S_IDLE;
          phy_rst_n_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_d   = S_PRE;
          bit_d     = '0;
          rd_d      = req_rd;
          tx_d      = {ST, (req_rd ? OP_RD : OP_WR), req_phy, req_reg, TA_WR};
          wdata_d   = req_wdata;
          ta_err_d  = 1'b0;
          mdio_o_d  = 1'b1;
          mdio_oe_d = 1'b1;
        end
      end
      S_PRE, S_HDR, S_TA, S_DATA: begin
        if (rise_tick) begin
          if (bit_q == BIT_TA2) ta_err_d = mdio_i;
          if (state_q == S_DATA) rx_d = {rx_q[14:0], mdio_i};
        end
        if (fall_tick) begin
          if (bit_q == BIT_LAST) begin
            state_d   = S_DONE;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
            if (rd_q) begin
              rd_data_d = rx_q;
              rd_err_d  = ta_err_q;
            end else begin
              rd_err_d = 1'b0;
            end
          end else begin
            bit_d = nb;
            // Header goes out of the 16-bit shifter first; once its last bit
            // is on the wire the shifter is reloaded with the write data.
            if (nb >= BIT_HDR) begin
              mdio_o_d = tx_q[15];
              tx_d     = (nb == BIT_TA2) ? wdata_q : {tx_q[14:0], 1'b0};
            end
            if (nb == BIT_HDR)  state_d = S_HDR;
            if (nb == BIT_TA)   state_d = S_TA;
            if (nb == BIT_DATA) state_d = S_DATA;
            if (rd_q && (nb >= BIT_TA)) begin
              mdio_o_d  = 1'b1;
              mdio_oe_d = 1'b0;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST_HOLD;
      bit_q       <= '0;
      hold_q      <= '0;
      tx_q        <= '0;
      wdata_q     <= '0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      rd_q        <= 1'b0;
      ta_err_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      phy_rst_n_q <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_q        <= rd_d;
      ta_err_q    <= ta_err_d;
      rd_err_q    <= rd_err_d;
      phy_rst_n_q <= phy_rst_n_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;
  assign phy_rst_n = phy_rst_n_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_eth_phy_mgmt_ctrl.sv
module tb_eth_phy_mgmt_ctrl;

  localparam int unsigned D         = 2;
  localparam int unsigned HOLD      = 20;
  localparam int unsigned FRAME_CYC = 128 * D;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rd = 1'b0;
  logic [4:0]  req_phy = '0;
  logic [4:0]  req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        req_ready, done, rd_err, phy_rst_n, eth_mdc, mdio_o, mdio_oe;
  logic [15:0] rd_data;

  eth_phy_mgmt_ctrl #(.CLK_DIV(D), .RST_HOLD(HOLD)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd   (req_rd),
    .req_phy  (req_phy),
    .req_reg  (req_reg),
    .req_wdata(req_wdata),
    .done     (done),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .phy_rst_n(phy_rst_n),
    .eth_mdc  (eth_mdc),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .mdio_i   (mdio_i)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] resp;
    logic        ta1;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int unsigned a;
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } sb_t;

  sb_t         sb_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned done_cnt = 0;
  int unsigned idle_mdc_bad = 0;
  int unsigned mon_bit = 0;
  logic [63:0] cur_drv = '1;
  logic [63:0] fdrv = '1;
  logic [63:0] cap_o = '0;
  logic [63:0] cap_oe = '0;
  logic        prev_mdc = 1'b0;
  logic        in_frame = 1'b0;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PHY drive pattern, index = frame bit number; pull-up (1) wherever the PHY is silent.
  function automatic logic [63:0] mk_drv(input logic [15:0] resp, input logic ta1);
    logic [63:0] d;
    d     = '1;
    d[47] = ta1;
    for (int j = 0; j < 16; j++) d[48 + j] = resp[15 - j];
    return d;
  endfunction

  // Monitor, PHY model and scoreboard consumer.
  initial begin
    sb_t         e;
    logic [63:0] exp_s, mask;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        in_frame = 1'b0;
        mon_bit  = 0;
        prev_mdc = 1'b0;
        mdio_i   = 1'b1;
        continue;
      end
      if (req_valid && req_ready) begin
        in_frame = 1'b1;
        mon_bit  = 0;
        cap_o    = '0;
        cap_oe   = '0;
        fdrv     = cur_drv;
        mdio_i   = fdrv[0];
      end else begin
        if (eth_mdc && !prev_mdc && mon_bit < 64) begin
          cap_o[63 - mon_bit]  = mdio_o;
          cap_oe[63 - mon_bit] = mdio_oe;
          mon_bit++;
        end
        if (!eth_mdc && prev_mdc && mon_bit < 64) mdio_i = fdrv[mon_bit];
        if (!in_frame && eth_mdc) idle_mdc_bad++;
      end
      prev_mdc = eth_mdc;
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 with no request outstanding, required 0");
        end else begin
          e     = sb_q.pop_front();
          exp_s = {32'hFFFF_FFFF, 2'b01, (e.rd ? 2'b10 : 2'b01), e.phy, e.regad, 2'b10, e.wdata};
          mask  = e.rd ? (64'hFFFF_FFFF_FFFF_FFFF << 18) : 64'hFFFF_FFFF_FFFF_FFFF;
          chk("done_cycle", 64'(cyc), 64'(e.a + 1 + FRAME_CYC));
          chk("mdc_rises", 64'(mon_bit), 64'd64);
          chk("mdio_stream", cap_o & mask, exp_s & mask);
          chk("mdio_oe", cap_oe, mask);
          chk("rd_data", 64'(rd_data), 64'(e.exp_rd));
          chk("rd_err", 64'(rd_err), 64'(e.exp_err));
        end
        in_frame = 1'b0;
      end
    end
  end

  task automatic issue(input vec_t v, input bit keep_valid, output int unsigned a);
    int unsigned n;
    sb_t         e;
    @(posedge sys_clk);
    #1;
    req_rd    = v.rd;
    req_phy   = v.phy;
    req_reg   = v.regad;
    req_wdata = v.wdata;
    cur_drv   = mk_drv(v.resp, v.ta1);
    req_valid = 1'b1;
    n = 0;
    a = 0;
    forever begin
      @(negedge sys_clk);
      if (req_ready) break;
      n++;
      if (n >= 2000) break;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready=0 required 1");
      req_valid = 1'b0;
    end else begin
      a         = cyc;
      e.a       = cyc;
      e.rd      = v.rd;
      e.phy     = v.phy;
      e.regad   = v.regad;
      e.wdata   = v.wdata;
      e.exp_rd  = v.exp_rd;
      e.exp_err = v.exp_err;
      sb_q.push_back(e);
      @(posedge sys_clk);
      #1;
      if (!keep_valid) begin
        req_valid = 1'b0;
        req_rd    = 1'($urandom);
        req_phy   = 5'($urandom);
        req_reg   = 5'($urandom);
        req_wdata = 16'($urandom);
      end
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: outstanding=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic measure_hold(output int unsigned n);
    n = 0;
    while (!phy_rst_n && n < 200) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int unsigned a1, a2, n, dc0;
    vec_t        b0, b1, wr_long;

    vecs[0] = '{1'b0, 5'h01, 5'h00, 16'h1140, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 5'h01, 5'h02, 16'h0000, 16'h0141, 1'b0, 16'h0141, 1'b0};
    vecs[2] = '{1'b1, 5'h01, 5'h03, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b0, 5'h1F, 5'h1F, 16'hA5C3, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b1, 5'h00, 5'h00, 16'h0000, 16'h8001, 1'b0, 16'h8001, 1'b0};
    vecs[5] = '{1'b1, 5'h1A, 5'h11, 16'h0000, 16'h1234, 1'b1, 16'h1234, 1'b1};
    b0      = '{1'b0, 5'h02, 5'h04, 16'h8421, 16'hFFFF, 1'b1, 16'h1234, 1'b0};
    b1      = '{1'b1, 5'h03, 5'h01, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
    wr_long = '{1'b0, 5'h1F, 5'h1F, 16'hA5C3, 16'hFFFF, 1'b1, 16'h0000, 1'b0};

    rst = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_outputs",
        64'({req_ready, done, rd_data, rd_err, phy_rst_n, eth_mdc, mdio_o, mdio_oe}),
        64'({1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    rst = 1'b0;
    measure_hold(n);
    chk("rst_hold_cycles", 64'(n), 64'(HOLD));
    chk("ready_with_phy_rst_n", 64'(req_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i], 1'b0, a1);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
    end

    issue(b0, 1'b1, a1);
    issue(b1, 1'b0, a2);
    chk("b2b_spacing", 64'(a2 - a1), 64'(FRAME_CYC + 2));
    wait_idle();

    // Reset in the middle of a write, while bit 40 is on the wire.
    issue(wr_long, 1'b0, a1);
    n = 0;
    while (mon_bit < 41 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("reach_bit40", 64'(mon_bit >= 41), 64'd1);
    #2;
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("midframe_reset_outputs",
        64'({req_ready, done, rd_data, rd_err, phy_rst_n, eth_mdc, mdio_o, mdio_oe}),
        64'({1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    sb_q.delete();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    measure_hold(n);
    chk("rst_hold_after_midframe", 64'(n), 64'(HOLD));
    chk("no_done_after_reset", 64'(done_cnt), 64'(dc0));

    issue(vecs[1], 1'b0, a1);
    wait_idle();
    repeat (4) @(posedge sys_clk);
    chk("mdc_idle_between_frames", 64'(idle_mdc_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
